// File: rtl/mem_arbiter_pkg.sv
// Shared types for the mina memory arbiter.
// Holds the 32-bit word and byte-strobe types reused across the core. It also
// holds the arbiter FSM state and bus-owner enums, the latched memory
// transaction struct, and the arbitration priority function.
package mem_arbiter_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

  typedef struct packed {
    u32_t   addr;
    u32_t   wrdata;
    wrstb_t wrstb;
  } mem_txn_t;

  // Width of the consecutive-data-grant counter; covers a streak limit of 1..15.
  localparam int STREAK_W = 4;

  // Data wins over fetch, except when the data streak has used up its quota
  // while a fetch is waiting.
  function automatic arb_owner_t pick_owner(input logic i_req,
                                            input logic d_req,
                                            input logic streak_full);
    if (d_req && !(i_req && streak_full)) begin
      return OWNER_D;
    end
    return OWNER_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the mina core ports, the arbiter and the memory controller.
// Signals:
//   i_req/i_addr/i_done/i_rddata              instruction-fetch port (read-only)
//   d_req/d_addr/d_wrdata/d_wrstb/d_done/d_rddata  data port (wrstb=0 is a read)
//   err                                        timeout flag, valid with a done pulse
//   mem_req/mem_addr/mem_wrdata/mem_wrstb/mem_ack/mem_rddata  memory side
// Modports:
//   slave  - the arbiter's view: takes requests, drives dones and the memory request
//   master - the environment's view: the core ports plus the memory controller
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic   i_req;
  u32_t   i_addr;
  logic   i_done;
  u32_t   i_rddata;

  logic   d_req;
  u32_t   d_addr;
  u32_t   d_wrdata;
  wrstb_t d_wrstb;
  logic   d_done;
  u32_t   d_rddata;

  logic   err;

  logic   mem_req;
  u32_t   mem_addr;
  u32_t   mem_wrdata;
  wrstb_t mem_wrstb;
  logic   mem_ack;
  u32_t   mem_rddata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wrdata, d_wrstb, mem_ack, mem_rddata,
    output i_done, i_rddata, d_done, d_rddata, err,
           mem_req, mem_addr, mem_wrdata, mem_wrstb
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wrdata, d_wrstb, mem_ack, mem_rddata,
    input  i_done, i_rddata, d_done, d_rddata, err,
           mem_req, mem_addr, mem_wrdata, mem_wrstb
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Transaction timeout counter for the memory arbiter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       returns the count to zero (used whenever no transaction is issued)
//   enable      counts one cycle of an outstanding memory request
//   expired     high during the TIMEOUT_CYCLES-th enabled cycle
// TIMEOUT_CYCLES = 0 disables the timeout entirely and expired is tied low.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
      localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

      logic [W-1:0] count;

      // The count stops at LAST so it can never wrap back to a non-expired value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && (count != LAST)) begin
          count <= count + W'(1);
        end
      end

      // Fires in the same cycle as the last allowed one, so the FSM can leave
      // ISSUE at the end of that cycle.
      assign expired = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the fetch and data ports of the
// mina core. Data has priority over fetch. A streak limit keeps a waiting
// fetch from starving. Each transaction runs IDLE -> ISSUE -> RESP. A timeout
// aborts a transaction the memory never acknowledges.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         mem_arbiter_if.slave: core request/done ports and memory req/ack
// All outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state, state_next;
  arb_owner_t          owner, grant_owner;
  mem_txn_t            txn, grant_txn;
  logic [STREAK_W-1:0] d_streak, streak_next;
  logic                grant;
  logic                complete;
  logic                resp_err;
  u32_t                resp_data;
  logic                timer_expired;

  logic                mem_req_q;
  logic                i_done_q, d_done_q, err_q;
  u32_t                i_rddata_q, d_rddata_q;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ISSUE),
    .enable (state == ISSUE),
    .expired(timer_expired)
  );

  // Next-state logic. Arbitration only happens in IDLE. In ISSUE, an ack that
  // arrives in the timeout cycle is checked first, so the ack wins.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_owner = OWNER_I;
    grant_txn   = '0;
    streak_next = d_streak;
    complete    = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant       = 1'b1;
          grant_owner = pick_owner(bus.i_req, bus.d_req, d_streak == STREAK_MAX);
          state_next  = ISSUE;
          if (grant_owner == OWNER_D) begin
            grant_txn.addr   = bus.d_addr;
            grant_txn.wrdata = bus.d_wrdata;
            grant_txn.wrstb  = bus.d_wrstb;
            // Only a data grant that overtakes a waiting fetch counts toward the streak.
            if (!bus.i_req) begin
              streak_next = '0;
            end else if (d_streak != STREAK_MAX) begin
              streak_next = d_streak + STREAK_W'(1);
            end
          end else begin
            grant_txn.addr = bus.i_addr;
            streak_next    = '0;
          end
        end
      end

      ISSUE: begin
        if (bus.mem_ack) begin
          complete   = 1'b1;
          resp_data  = bus.mem_rddata;
          state_next = RESP;
        end else if (timer_expired) begin
          complete   = 1'b1;
          resp_err   = 1'b1;
          state_next = RESP;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      d_streak <= '0;
    end else begin
      state    <= state_next;
      d_streak <= streak_next;
    end
  end

  // Registered bus outputs. The done pulses are set on the ISSUE->RESP edge,
  // so they line up with the single RESP cycle. mem_req drops on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= OWNER_I;
      txn        <= '0;
      mem_req_q  <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      i_rddata_q <= '0;
      d_rddata_q <= '0;
    end else begin
      if (grant) begin
        owner <= grant_owner;
        txn   <= grant_txn;
      end
      mem_req_q <= (state_next == ISSUE);
      i_done_q  <= complete && (owner == OWNER_I);
      d_done_q  <= complete && (owner == OWNER_D);
      err_q     <= complete && resp_err;
      if (complete && (owner == OWNER_I)) begin
        i_rddata_q <= resp_data;
      end
      if (complete && (owner == OWNER_D)) begin
        d_rddata_q <= resp_data;
      end
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = txn.addr;
  assign bus.mem_wrdata = txn.wrdata;
  assign bus.mem_wrstb  = txn.wrstb;
  assign bus.i_done     = i_done_q;
  assign bus.d_done     = d_done_q;
  assign bus.err        = err_q;
  assign bus.i_rddata   = i_rddata_q;
  assign bus.d_rddata   = d_rddata_q;

endmodule
